// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures up to LANES retired instructions per cycle
// into an all-or-nothing FIFO. It also keeps cycle and instruction counters
// and halts capture on a trap instruction.
module commit_trace_buffer #(
    parameter int          LANES      = 2,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] TRAP_INSTR = 32'h8000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [LANES-1:0]      commit_valid_i,
    input  logic [32*LANES-1:0]   commit_pc_i,
    input  logic [32*LANES-1:0]   commit_instr_i,
    input  logic [LANES-1:0]      commit_wreg_i,
    input  logic [5*LANES-1:0]    commit_waddr_i,
    input  logic [32*LANES-1:0]   commit_wdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_pc_o,
    output logic [31:0]           out_instr_o,
    output logic                  out_wreg_o,
    output logic [4:0]            out_waddr_o,
    output logic [31:0]           out_wdata_o,
    output logic [63:0]           cycle_cnt_o,
    output logic [63:0]           instr_cnt_o,
    output logic                  trap_o,
    output logic [31:0]           trap_pc_o,
    output logic                  overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(LANES + 1);

    // Record storage (not reset; only the pointers define valid contents)
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic        wreg_mem  [DEPTH];
    logic [4:0]  waddr_mem [DEPTH];
    logic [31:0] wdata_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [63:0]   cycle_q, cycle_d;
    logic [63:0]   icnt_q, icnt_d;
    logic          trap_q, trap_d;
    logic [31:0]   trap_pc_q, trap_pc_d;
    logic          ovf_q, ovf_d;

    logic [LANES-1:0] accept;
    logic [AW-1:0]    rank [LANES];
    logic [CW-1:0]    n_acc;
    logic             stop;
    logic             trap_hit;
    logic [31:0]      trap_hit_pc;
    logic [LW-1:0]    free_slots;
    logic             fits;
    logic             pop;

    // Lane acceptance: lanes below and including the first trap lane are taken,
    // each accepted lane gets a compacted slot offset (rank) for the write
    always_comb begin
        accept      = '0;
        n_acc       = '0;
        stop        = 1'b0;
        trap_hit    = 1'b0;
        trap_hit_pc = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            rank[k] = AW'(n_acc);
            if (commit_valid_i[k] && enable_i && !trap_q && !stop) begin
                accept[k] = 1'b1;
                n_acc     = n_acc + CW'(1);
                if (commit_instr_i[32*k +: 32] == TRAP_INSTR) begin
                    stop        = 1'b1;
                    trap_hit    = 1'b1;
                    trap_hit_pc = commit_pc_i[32*k +: 32];
                end
            end
        end
    end

    // Next-state: free space is taken before this cycle's pop, so a pop never
    // makes room for a same-cycle push
    always_comb begin
        free_slots = LW'(DEPTH) - level_q;
        fits       = (LW'(n_acc) <= free_slots);
        pop        = (level_q != '0) && out_ready_i;
        level_d    = level_q + (fits ? LW'(n_acc) : '0) - LW'(pop);
        wr_ptr_d   = wr_ptr_q + (fits ? AW'(n_acc) : '0);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        icnt_d     = icnt_q + 64'(n_acc);
        cycle_d    = trap_q ? cycle_q : cycle_q + 64'd1;
        ovf_d      = ovf_q | ~fits;
        trap_d     = trap_q | trap_hit;
        trap_pc_d  = trap_hit ? trap_hit_pc : trap_pc_q;
    end

    // Control and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cycle_q   <= '0;
            icnt_q    <= '0;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            cycle_q   <= cycle_d;
            icnt_q    <= icnt_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
            ovf_q     <= ovf_d;
        end
    end

    // Record writes: each accepted lane lands at wr_ptr + its rank
    always_ff @(posedge clock) begin
        if (!reset && fits) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (accept[k]) begin
                    pc_mem[wr_ptr_q + rank[k]]    <= commit_pc_i[32*k +: 32];
                    instr_mem[wr_ptr_q + rank[k]] <= commit_instr_i[32*k +: 32];
                    wreg_mem[wr_ptr_q + rank[k]]  <= commit_wreg_i[k];
                    waddr_mem[wr_ptr_q + rank[k]] <= commit_waddr_i[5*k +: 5];
                    wdata_mem[wr_ptr_q + rank[k]] <= commit_wdata_i[32*k +: 32];
                end
            end
        end
    end

    assign out_valid_o = (level_q != '0);
    assign out_pc_o    = pc_mem[rd_ptr_q];
    assign out_instr_o = instr_mem[rd_ptr_q];
    assign out_wreg_o  = wreg_mem[rd_ptr_q];
    assign out_waddr_o = waddr_mem[rd_ptr_q];
    assign out_wdata_o = wdata_mem[rd_ptr_q];
    assign cycle_cnt_o = cycle_q;
    assign instr_cnt_o = icnt_q;
    assign trap_o      = trap_q;
    assign trap_pc_o   = trap_pc_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam logic [31:0] TRAP = 32'h8000_0000;
    localparam int          NL   = 2;
    localparam int          ND   = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  valid = '0;
    logic [63:0] pc = '0;
    logic [63:0] instr = '0;
    logic [1:0]  wreg = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic        ready = 1'b0;

    logic        out_valid, out_wreg, trap, ovf;
    logic [31:0] out_pc, out_instr, out_wdata, trap_pc;
    logic [4:0]  out_waddr;
    logic [63:0] cyc_cnt, ins_cnt;

    int checks = 0;
    int failures = 0;

    // reference model state
    rec_t        mq[$];
    logic [63:0] m_cyc = '0;
    logic [63:0] m_icnt = '0;
    logic        m_trap = 1'b0;
    logic [31:0] m_tpc = '0;
    logic        m_ovf = 1'b0;

    commit_trace_buffer #(.LANES(NL), .DEPTH(ND), .TRAP_INSTR(TRAP)) dut (
        .clock(clock), .reset(reset), .enable_i(en),
        .commit_valid_i(valid), .commit_pc_i(pc), .commit_instr_i(instr),
        .commit_wreg_i(wreg), .commit_waddr_i(waddr), .commit_wdata_i(wdata),
        .out_valid_o(out_valid), .out_ready_i(ready),
        .out_pc_o(out_pc), .out_instr_o(out_instr), .out_wreg_o(out_wreg),
        .out_waddr_o(out_waddr), .out_wdata_o(out_wdata),
        .cycle_cnt_o(cyc_cnt), .instr_cnt_o(ins_cnt),
        .trap_o(trap), .trap_pc_o(trap_pc), .overflow_o(ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
            chk("out_wreg", 64'(out_wreg), 64'(mq[0].wreg));
            chk("out_waddr", 64'(out_waddr), 64'(mq[0].waddr));
            chk("out_wdata", 64'(out_wdata), 64'(mq[0].wdata));
        end
        chk("cycle_cnt", cyc_cnt, m_cyc);
        chk("instr_cnt", ins_cnt, m_icnt);
        chk("trap", 64'(trap), 64'(m_trap));
        chk("trap_pc", 64'(trap_pc), 64'(m_tpc));
        chk("overflow", 64'(ovf), 64'(m_ovf));
    endtask

    // One clock of the architectural rules applied to the currently driven inputs
    task automatic model_update();
        rec_t        acc[$];
        rec_t        r;
        bit          hit;
        bit          dopop;
        logic [31:0] hpc;
        int          freeslots;
        hit = 0;
        hpc = '0;
        if (reset) begin
            mq.delete();
            m_cyc = '0; m_icnt = '0; m_trap = 1'b0; m_tpc = '0; m_ovf = 1'b0;
        end else begin
            for (int k = 0; k < NL; k++) begin
                if (!hit && valid[k] && en && !m_trap) begin
                    r.pc = pc[32*k +: 32];
                    r.instr = instr[32*k +: 32];
                    r.wreg = wreg[k];
                    r.waddr = waddr[5*k +: 5];
                    r.wdata = wdata[32*k +: 32];
                    acc.push_back(r);
                    if (r.instr == TRAP) begin
                        hit = 1;
                        hpc = r.pc;
                    end
                end
            end
            freeslots = ND - mq.size();
            dopop = (mq.size() != 0) && ready;
            if (acc.size() <= freeslots) begin
                foreach (acc[i]) mq.push_back(acc[i]);
            end else begin
                m_ovf = 1'b1;
            end
            if (dopop) void'(mq.pop_front());
            m_icnt = m_icnt + 64'(acc.size());
            if (!m_trap) m_cyc = m_cyc + 64'd1;
            if (hit) begin
                m_trap = 1'b1;
                m_tpc = hpc;
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_all();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int k, input logic v, input logic [31:0] p, input logic [31:0] ins);
        valid[k] = v;
        pc[32*k +: 32] = p;
        instr[32*k +: 32] = ins;
        wreg[k] = 1'($urandom);
        waddr[5*k +: 5] = 5'($urandom);
        wdata[32*k +: 32] = $urandom;
    endtask

    task automatic dual(input logic [31:0] p);
        set_lane(0, 1'b1, p, $urandom & 32'h7fff_ffff);
        set_lane(1, 1'b1, p + 32'd4, $urandom & 32'h7fff_ffff);
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        // reset state
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_cycle", cyc_cnt, 64'd0);
        reset = 1'b0;

        // two records in pc order
        en = 1'b1; ready = 1'b1;
        dual(32'h1c00_0000);
        step();
        valid = '0;
        chk("basic_icnt", ins_cnt, 64'd2);
        chk("basic_pc0", 64'(out_pc), 64'h1c00_0000);
        step();
        chk("basic_pc1", 64'(out_pc), 64'h1c00_0004);
        step();
        step();

        // fill to DEPTH, then one more dual commit overflows
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dual(32'h2000_0000 + 32'(i * 8));
            step();
        end
        chk("full_ovf", 64'(ovf), 64'd0);
        dual(32'h2000_1000);
        step();
        valid = '0;
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_icnt", ins_cnt, 64'd18);
        ready = 1'b1;
        repeat (17) step();

        // level 15 with a same-cycle pop: pop does not free space
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            dual(32'h3000_0000 + 32'(i * 8));
            step();
        end
        set_lane(0, 1'b1, 32'h3000_0100, 32'h13);
        valid[1] = 1'b0;
        step();
        ready = 1'b1;
        dual(32'h3000_0200);
        step();
        valid = '0;
        chk("l15_ovf", 64'(ovf), 64'd1);
        repeat (16) step();

        // trap on lane0 discards lane1, freezes cycle count
        do_reset();
        ready = 1'b0;
        set_lane(0, 1'b1, 32'h1c00_0100, TRAP);
        set_lane(1, 1'b1, 32'h1c00_0104, 32'h13);
        step();
        chk("trap_set", 64'(trap), 64'd1);
        chk("trap_pc_v", 64'(trap_pc), 64'h1c00_0100);
        chk("trap_icnt", ins_cnt, 64'd1);
        dual(32'h1c00_0200);
        repeat (3) step();
        valid = '0;
        chk("trap_frozen", cyc_cnt, 64'd1);
        chk("trap_nocommit", ins_cnt, 64'd1);
        ready = 1'b1;
        repeat (3) step();

        // enable low: nothing accepted, cycles still counted
        do_reset();
        en = 1'b0;
        dual(32'h4000_0000);
        repeat (3) step();
        chk("en0_icnt", ins_cnt, 64'd0);
        chk("en0_cycle", cyc_cnt, 64'd3);
        chk("en0_valid", 64'(out_valid), 64'd0);
        en = 1'b1;

        // reset with buffered records and trap set
        do_reset();
        ready = 1'b0;
        dual(32'h5000_0000); step();
        dual(32'h5000_0010); step();
        set_lane(0, 1'b1, 32'h5000_0020, TRAP);
        valid[1] = 1'b0;
        step();
        valid = '0;
        step();
        reset = 1'b1;
        step();
        chk("r2_valid", 64'(out_valid), 64'd0);
        chk("r2_trap", 64'(trap), 64'd0);
        chk("r2_tpc", 64'(trap_pc), 64'd0);
        chk("r2_icnt", ins_cnt, 64'd0);
        reset = 1'b0;
        ready = 1'b1;
        dual(32'h6000_0000);
        step();
        valid = '0;
        chk("r2_new", 64'(out_valid), 64'd1);
        step();
        step();

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0) || (m_trap && $urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 7) != 0);
            ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < NL; k++)
                set_lane(k, 1'($urandom), $urandom,
                         ($urandom_range(0, 24) == 0) ? TRAP : ($urandom & 32'h7fff_ffff));
            step();
        end
        reset = 1'b0; valid = '0; ready = 1'b1;
        repeat (18) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
